// File: rtl/rf_ctx_xfer_pkg.sv
// Shared RF write-enable encodings and the context-transfer state type.
// The macros are guarded so that other RF files can also define them.
`ifndef RF_WRITE_NONE
`define RF_WRITE_NONE 2'b00
`define RF_WRITE_LOW  2'b01
`define RF_WRITE_HIGH 2'b10
`define RF_WRITE_FULL 2'b11
`endif

package rf_ctx_xfer_pkg;

  localparam int CTX_NREGS = 8;
  localparam int CTX_AW    = 16;
  localparam int CTX_DW    = 16;

  typedef enum logic [2:0] {
    CTX_IDLE,
    CTX_SAVE,
    CTX_RD_REQ,
    CTX_RD_WAIT,
    CTX_DONE
  } ctx_state_t;

endpackage

// File: rtl/rf_ctx_xfer.sv
// Context save/restore engine: moves r0..r(NREGS-1) between the register file
// and a data-memory save area. It owns RF port A while busy.
module rf_ctx_xfer
  import rf_ctx_xfer_pkg::*;
#(
  parameter int NREGS = CTX_NREGS,
  parameter int AW    = CTX_AW,
  parameter int DW    = CTX_DW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_save,
  input  logic          start_restore,
  input  logic [AW-1:0] base_addr,
  output logic          busy,
  output logic          done,
  output logic [2:0]    rf_addr,
  output logic [1:0]    rf_write,
  output logic [DW-1:0] rf_din,
  input  logic [DW-1:0] rf_dout,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_re,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata
);

  ctx_state_t    state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] addr_sum;
  logic          last;

  // Save area is addressed modulo 2^AW, so wrapping past the top is intended.
  assign addr_sum = base_q + AW'(idx_q);
  assign last     = (idx_q == 3'(NREGS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= CTX_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    base_d    = base_q;
    busy      = 1'b0;
    done      = 1'b0;
    rf_addr   = '0;
    rf_write  = `RF_WRITE_NONE;
    rf_din    = '0;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    mem_re    = 1'b0;
    case (state_q)
      CTX_IDLE: begin
        // Save takes priority when both starts arrive together.
        if (start_save || start_restore) begin
          state_d = start_save ? CTX_SAVE : CTX_RD_REQ;
          idx_d   = '0;
          base_d  = base_addr;
        end
      end
      CTX_SAVE: begin
        busy      = 1'b1;
        rf_addr   = idx_q;
        mem_we    = 1'b1;
        mem_addr  = addr_sum;
        mem_wdata = rf_dout;
        if (mem_ready) begin
          if (last) state_d = CTX_DONE;
          else      idx_d   = idx_q + 3'd1;
        end
      end
      CTX_RD_REQ: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = addr_sum;
        if (mem_ready) state_d = CTX_RD_WAIT;
      end
      CTX_RD_WAIT: begin
        // Read data is valid exactly one cycle after acceptance; write it now.
        busy     = 1'b1;
        rf_addr  = idx_q;
        rf_din   = mem_rdata;
        rf_write = `RF_WRITE_FULL;
        if (last) begin
          state_d = CTX_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = CTX_RD_REQ;
        end
      end
      CTX_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = CTX_IDLE;
      end
      default: state_d = CTX_IDLE;
    endcase
  end

endmodule
